// File: rtl/cmd_loader_if.sv
// -----------------------------------------------------------------------------
// cmd_loader_if
// Bundles the cmd_loader control, input-stream and memory-write signals.
//   slave  modport : seen by cmd_loader (receives control + stream, drives
//                    s_ready, the cmd_mem write port, busy/done[/cksum])
//   master modport : seen by whoever drives the loader (controller / bench)
// Optional macro CMD_LOADER_CKSUM_EN adds the cksum signal.
// -----------------------------------------------------------------------------
interface cmd_loader_if #(
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH     = 32
);
    logic                      load_start;
    logic [CMD_ADDR_WIDTH-1:0] load_base_addr;
    logic [CMD_ADDR_WIDTH-1:0] load_count;
    logic                      load_abort;
    logic [WORD_WIDTH-1:0]     s_data;
    logic                      s_valid;
    logic                      s_ready;
    logic [CMD_WIDTH-1:0]      cmd_write;
    logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr;
    logic                      cmd_write_enable;
    logic                      busy;
    logic                      done;
`ifdef CMD_LOADER_CKSUM_EN
    logic [WORD_WIDTH-1:0]     cksum;
`endif

    modport slave (
        input  load_start, load_base_addr, load_count, load_abort, s_data, s_valid,
`ifdef CMD_LOADER_CKSUM_EN
        output cksum,
`endif
        output s_ready, cmd_write, cmd_write_addr, cmd_write_enable, busy, done
    );

    modport master (
        output load_start, load_base_addr, load_count, load_abort, s_data, s_valid,
`ifdef CMD_LOADER_CKSUM_EN
        input  cksum,
`endif
        input  s_ready, cmd_write, cmd_write_addr, cmd_write_enable, busy, done
    );
endinterface

// File: rtl/cmd_loader.sv
// -----------------------------------------------------------------------------
// cmd_loader
// Packs a 32-bit valid/ready word stream into CMD_WIDTH commands and writes a
// block of load_count commands into cmd_mem starting at load_base_addr, then
// pulses done. Word 0 of each command lands in bits [WORD_WIDTH-1:0].
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : cmd_loader_if.slave -- load_start/base/count/abort in,
//              s_data/s_valid in, s_ready out, cmd_write/addr/enable out,
//              busy/done out (cksum out when CMD_LOADER_CKSUM_EN is defined)
// Optional feature macro: CMD_LOADER_CKSUM_EN (XOR checksum of accepted words).
// -----------------------------------------------------------------------------
module cmd_loader #(
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    cmd_loader_if.slave  bus
);
    localparam int WORDS_PER_CMD = CMD_WIDTH / WORD_WIDTH;
    localparam int IDX_W         = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_CMD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                r_state;
    logic [IDX_W-1:0]          r_word_idx;
    logic [CMD_WIDTH-1:0]      r_pack;
    logic [CMD_ADDR_WIDTH-1:0] r_addr;
    logic [CMD_ADDR_WIDTH-1:0] r_cmds_left;
    logic                      r_s_ready;
    logic                      r_wr_en;
    logic [CMD_WIDTH-1:0]      r_wr_data;
    logic [CMD_ADDR_WIDTH-1:0] r_wr_addr;
`ifdef CMD_LOADER_CKSUM_EN
    logic [WORD_WIDTH-1:0]     r_cksum;
`endif

    logic                      w_hs;
    logic                      w_last_slot;
    logic [CMD_WIDTH-1:0]      w_pack_next;

    // s_ready is only ever high in LOAD, so it doubles as the handshake gate.
    assign w_hs        = r_s_ready & bus.s_valid;
    assign w_last_slot = (r_word_idx == LAST_IDX);

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_word_idx*WORD_WIDTH +: WORD_WIDTH] = bus.s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_word_idx  <= '0;
            r_pack      <= '0;
            r_addr      <= '0;
            r_cmds_left <= '0;
            r_s_ready   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
`ifdef CMD_LOADER_CKSUM_EN
            r_cksum     <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Abort wins over a coincident start.
                    if (bus.load_start && !bus.load_abort) begin
                        r_addr      <= bus.load_base_addr;
                        r_cmds_left <= bus.load_count;
                        r_word_idx  <= '0;
                        r_pack      <= '0;
`ifdef CMD_LOADER_CKSUM_EN
                        r_cksum     <= '0;
`endif
                        if (bus.load_count != '0) begin
                            r_state   <= S_LOAD;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.load_abort) begin
                        // Discard any partial command; a completing word is dropped too.
                        r_state    <= S_IDLE;
                        r_s_ready  <= 1'b0;
                        r_word_idx <= '0;
                        r_pack     <= '0;
                    end else begin
                        // Final strobe is on the port this cycle: finish next cycle.
                        if (r_wr_en && (r_cmds_left == '0))
                            r_state <= S_DONE;
                        if (w_hs) begin
`ifdef CMD_LOADER_CKSUM_EN
                            r_cksum <= r_cksum ^ bus.s_data;
`endif
                            if (w_last_slot) begin
                                r_word_idx  <= '0;
                                r_pack      <= '0;
                                r_wr_en     <= 1'b1;
                                r_wr_data   <= w_pack_next;
                                r_wr_addr   <= r_addr;
                                r_addr      <= r_addr + 1'b1;   // wraps mod 2^CMD_ADDR_WIDTH
                                r_cmds_left <= r_cmds_left - 1'b1;
                                if (r_cmds_left == CMD_ADDR_WIDTH'(1))
                                    r_s_ready <= 1'b0;
                            end else begin
                                r_word_idx  <= r_word_idx + 1'b1;
                                r_pack      <= w_pack_next;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready          = r_s_ready;
    assign bus.cmd_write        = r_wr_data;
    assign bus.cmd_write_addr   = r_wr_addr;
    assign bus.cmd_write_enable = r_wr_en;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.done             = (r_state == S_DONE);
`ifdef CMD_LOADER_CKSUM_EN
    assign bus.cksum            = r_cksum;
`endif

endmodule

// File: tb/tb_cmd_loader.sv
// -----------------------------------------------------------------------------
// tb_cmd_loader
// Directed bench for cmd_loader. Stimulus pushes expected memory writes and
// done pulses into queues; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_cmd_loader;
    localparam int CW = 128;
    localparam int AW = 16;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cmd_loader_if #(.CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus();

    cmd_loader #(.CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    bit  done_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [CW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [AW-1:0] c);
        bus.load_base_addr = a;
        bus.load_count     = c;
        bus.load_start     = 1'b1;
        step();
        bus.load_start     = 1'b0;
    endtask

    task automatic send(input logic [WW-1:0] d, input bit gaps, input bit with_abort);
        bit ok;
        bit rdy;
        ok = 1'b0;
        if (gaps && ($urandom_range(0, 1) == 1))
            repeat ($urandom_range(1, 2)) step();
        bus.s_data     = d;
        bus.s_valid    = 1'b1;
        bus.load_abort = with_abort;
        for (int t = 0; t < 40; t++) begin
            rdy = bus.s_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.s_valid    = 1'b0;
        bus.load_abort = 1'b0;
        chk("word_accepted", CW'(ok), CW'(1));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("done_seen", CW'(ok), CW'(1));
    endtask

    task automatic check_drained(input string name);
        chk({name, "_writes_left"}, CW'(exp_q.size()), CW'(0));
        chk({name, "_dones_left"}, CW'(done_q.size()), CW'(0));
        chk({name, "_idle"}, CW'(bus.busy), CW'(0));
    endtask

    // Scoreboard monitor
    initial begin : monitor
        bit  prev_we;
        bit  e;
        wr_t w;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_we = 1'b0;
            end else begin
                if (bus.cmd_write_enable) begin
                    chk("write_expected", CW'(exp_q.size() != 0), CW'(1));
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        chk("write_addr", CW'(bus.cmd_write_addr), CW'(w.addr));
                        chk("write_data", bus.cmd_write, w.data);
                    end
                end
                if (bus.done) begin
                    chk("done_expected", CW'(done_q.size() != 0), CW'(1));
                    if (done_q.size() != 0) begin
                        e = done_q.pop_front();
                        chk("done_after_write", CW'(prev_we), CW'(e));
                    end
                end
                prev_we = bus.cmd_write_enable;
            end
        end
    end

    initial begin : stim
        bus.load_start     = 1'b0;
        bus.load_base_addr = '0;
        bus.load_count     = '0;
        bus.load_abort     = 1'b0;
        bus.s_data         = '0;
        bus.s_valid        = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_s_ready", CW'(bus.s_ready), CW'(0));
        chk("rst_busy", CW'(bus.busy), CW'(0));
        chk("rst_done", CW'(bus.done), CW'(0));
        chk("rst_we", CW'(bus.cmd_write_enable), CW'(0));
        chk("rst_data", bus.cmd_write, CW'(0));
        reset_n = 1'b1;
        step();

        // Back-to-back, base 0x0010, count 2
        push_wr(16'h0010, 128'h00000044_00000033_00000022_00000011);
        push_wr(16'h0011, 128'h00000088_00000077_00000066_00000055);
        done_q.push_back(1'b1);
        start(16'h0010, 16'd2);
        chk("s_ready_after_start", CW'(bus.s_ready), CW'(1));
        for (int i = 1; i <= 8; i++) send(WW'(i * 'h11), 1'b0, 1'b0);
        wait_done();
        step();
        check_drained("b2b");

        // 50% gaps, count 3, with an ignored start mid-load
        push_wr(16'h0020, 128'h00000004_00000003_00000002_00000001);
        push_wr(16'h0021, 128'h00000008_00000007_00000006_00000005);
        push_wr(16'h0022, 128'h0000000C_0000000B_0000000A_00000009);
        done_q.push_back(1'b1);
        start(16'h0020, 16'd3);
        for (int i = 1; i <= 12; i++) begin
            send(WW'(i), 1'b1, 1'b0);
            if (i == 5) start(16'h0099, 16'd5);
        end
        wait_done();
        step();
        check_drained("gaps");

        // Address wrap
        push_wr(16'hFFFF, 128'h000000A3_000000A2_000000A1_000000A0);
        push_wr(16'h0000, 128'h000000A7_000000A6_000000A5_000000A4);
        done_q.push_back(1'b1);
        start(16'hFFFF, 16'd2);
        for (int i = 0; i < 8; i++) send(WW'('hA0 + i), 1'b0, 1'b0);
        wait_done();
        step();
        check_drained("wrap");

        // Count 0
        done_q.push_back(1'b0);
        start(16'h0030, 16'd0);
        chk("cnt0_done", CW'(bus.done), CW'(1));
        chk("cnt0_s_ready", CW'(bus.s_ready), CW'(0));
        step();
        chk("cnt0_done_clear", CW'(bus.done), CW'(0));
        for (int i = 0; i < 3; i++) begin
            chk("cnt0_s_ready_low", CW'(bus.s_ready), CW'(0));
            step();
        end
        check_drained("cnt0");

        // Abort after 2 words of cmd 1
        push_wr(16'h0040, 128'h000000C3_000000C2_000000C1_000000C0);
        start(16'h0040, 16'd2);
        for (int i = 0; i < 6; i++) send(WW'('hC0 + i), 1'b0, 1'b0);
        bus.load_abort = 1'b1;
        step();
        bus.load_abort = 1'b0;
        chk("abort_s_ready", CW'(bus.s_ready), CW'(0));
        repeat (3) step();
        check_drained("abort");

        // New load after abort packs from slot 0
        push_wr(16'h0050, 128'h000000B3_000000B2_000000B1_000000B0);
        done_q.push_back(1'b1);
        start(16'h0050, 16'd1);
        for (int i = 0; i < 4; i++) send(WW'('hB0 + i), 1'b0, 1'b0);
        wait_done();
        step();
        check_drained("reload");

        // Abort coincident with the completing handshake
        start(16'h0060, 16'd1);
        for (int i = 0; i < 3; i++) send(WW'('hD0 + i), 1'b0, 1'b0);
        send(32'h000000D3, 1'b0, 1'b1);
        repeat (3) step();
        check_drained("abort_hs");

        // Reset mid-stream with the last word being presented
        start(16'h0070, 16'd1);
        for (int i = 0; i < 3; i++) send(WW'('hE0 + i), 1'b0, 1'b0);
        chk("pre_reset_busy", CW'(bus.busy), CW'(1));
        bus.s_data  = 32'h000000E3;
        bus.s_valid = 1'b1;
        reset_n     = 1'b0;
        #1;
        chk("mid_rst_s_ready", CW'(bus.s_ready), CW'(0));
        chk("mid_rst_busy", CW'(bus.busy), CW'(0));
        chk("mid_rst_we", CW'(bus.cmd_write_enable), CW'(0));
        chk("mid_rst_addr", CW'(bus.cmd_write_addr), CW'(0));
        chk("mid_rst_data", bus.cmd_write, CW'(0));
        bus.s_valid = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("post_rst_s_ready", CW'(bus.s_ready), CW'(0));
        check_drained("reset");

`ifdef CMD_LOADER_CKSUM_EN
        push_wr(16'h0080, 128'h00000008_00000004_00000002_00000001);
        done_q.push_back(1'b1);
        start(16'h0080, 16'd1);
        chk("cksum_cleared", CW'(bus.cksum), CW'(0));
        send(32'h1, 1'b0, 1'b0);
        send(32'h2, 1'b0, 1'b0);
        send(32'h4, 1'b0, 1'b0);
        send(32'h8, 1'b0, 1'b0);
        wait_done();
        chk("cksum_at_done", CW'(bus.cksum), CW'(32'h0000000F));
        step();
        chk("cksum_held", CW'(bus.cksum), CW'(32'h0000000F));
        check_drained("cksum");
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
